// File: rtl/timer_mc.sv
// timer_mc: multi-channel prescaled timer with per-channel expiry interrupts
// Per-channel map at addr[7:4]: 0x0 CTRL, 0x4 COUNT, 0x8 EVALUE, 0xC PRESCALE.
module timer_mc #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PSC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [31:0]       wr_addr_i,
    input  logic [31:0]       wr_data_i,
    input  logic [31:0]       rd_addr_i,
    output logic [31:0]       rd_data_o,
    output logic [NUM_CH-1:0] irq_o,
    output logic              timer_int_flag_o
);
    logic [7:0]  r_rd_addr;
    logic [31:0] w_ctrl [NUM_CH];
    logic [31:0] w_cnt  [NUM_CH];
    logic [31:0] w_ev   [NUM_CH];
    logic [31:0] w_pre  [NUM_CH];
    logic        w_unused;

    assign w_unused = ^{wr_addr_i[31:8], rd_addr_i[31:8], wr_data_i};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             r_en, r_ie, r_pend, r_mode;
        logic [CNT_W-1:0] r_cnt, r_ev;
        logic [PSC_W-1:0] r_psc, r_pre;
        logic             w_sel, w_ctrl_wr, w_exp, w_tick;
        assign w_sel     = wr_en_i && wr_addr_i[7:4] == 4'(i);
        assign w_ctrl_wr = w_sel && wr_addr_i[3:0] == 4'h0;
        assign w_exp     = r_en && r_cnt >= r_ev;
        assign w_tick    = r_en && r_psc == r_pre;
        // Hardware expiry outranks a same-cycle software clear of PEND.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_en   <= 1'b0;
                r_ie   <= 1'b0;
                r_pend <= 1'b0;
                r_mode <= 1'b0;
                r_cnt  <= '0;
                r_ev   <= '0;
                r_psc  <= '0;
                r_pre  <= '0;
            end else begin
                r_cnt  <= (!r_en || w_exp) ? '0 : r_cnt + CNT_W'(w_tick);
                r_psc  <= (!r_en || w_exp || w_tick) ? '0 : r_psc + PSC_W'(1);
                r_en   <= w_ctrl_wr ? wr_data_i[0] : (w_exp ? r_mode : r_en);
                r_ie   <= w_ctrl_wr ? wr_data_i[1] : r_ie;
                r_mode <= w_ctrl_wr ? wr_data_i[3] : r_mode;
                r_pend <= w_exp | (r_pend & (!w_ctrl_wr | wr_data_i[2]));
                if (w_sel && wr_addr_i[3:0] == 4'h8) r_ev <= wr_data_i[CNT_W-1:0];
                if (w_sel && wr_addr_i[3:0] == 4'hC) r_pre <= wr_data_i[PSC_W-1:0];
            end
        end
        assign w_ctrl[i] = {28'd0, r_mode, r_pend, r_ie, r_en};
        assign w_cnt[i]  = 32'(r_cnt);
        assign w_ev[i]   = 32'(r_ev);
        assign w_pre[i]  = 32'(r_pre);
        assign irq_o[i]  = r_pend & r_ie;
    end

    assign timer_int_flag_o = |irq_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rd_addr <= '0;
        else        r_rd_addr <= rd_addr_i[7:0];
    end

    always_comb begin
        rd_data_o = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (r_rd_addr[7:4] == 4'(c))
                rd_data_o = r_rd_addr[3:0] == 4'h0 ? w_ctrl[c] :
                            r_rd_addr[3:0] == 4'h4 ? w_cnt[c]  :
                            r_rd_addr[3:0] == 4'h8 ? w_ev[c]   :
                            r_rd_addr[3:0] == 4'hC ? w_pre[c]  : 32'd0;
    end
endmodule

// File: tb/tb_timer_mc.sv
// tb_timer_mc: table vectors, directed corner sequences and a randomized run
// checked against an elapsed-cycle model of each timer channel.
module tb_timer_mc;
    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           wr_en_i = 1'b0;
    logic [31:0]    wr_addr_i = '0;
    logic [31:0]    wr_data_i = '0;
    logic [31:0]    rd_addr_i = '0;
    logic [31:0]    rd_data_o;
    logic [NCH-1:0] irq_o;
    logic           timer_int_flag_o;
    int             n_err = 0;
    int             n_chk = 0;

    always #5 clk = ~clk;

    timer_mc #(.NUM_CH(NCH), .CNT_W(32), .PSC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .irq_o(irq_o), .timer_int_flag_o(timer_int_flag_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] ra;
        logic [31:0] ex;
    } vec_t;
    vec_t tbl [14];

    // Model: a channel is described by cycles elapsed since it (re)started.
    bit          m_en [NCH];
    bit          m_ie [NCH];
    bit          m_pend [NCH];
    bit          m_mode [NCH];
    logic [31:0] m_ev [NCH];
    logic [15:0] m_pr [NCH];
    longint      m_t [NCH];
    logic [7:0]  m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en_i = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        @(negedge clk);
        wr_en_i = 1'b0;
    endtask

    task automatic wait_irq(input int ch, input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (irq_o[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    function automatic logic [31:0] m_count(input int c);
        return 32'(m_t[c] / (longint'(m_pr[c]) + 1));
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int c;
        c = int'(a[7:4]);
        if (c >= NCH) return 32'd0;
        case (a[3:0])
            4'h0:    return {28'd0, m_mode[c], m_pend[c], m_ie[c], m_en[c]};
            4'h4:    return m_count(c);
            4'h8:    return m_ev[c];
            4'hC:    return {16'd0, m_pr[c]};
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int          n, seen, op, c, off;
        bit          we, xp;
        logic [31:0] a, d;
        logic [7:0]  ra;
        logic [NCH-1:0] ex_irq;

        tbl[0]  = '{1'b0, 32'h00, 32'h0,        32'h00, 32'h0};
        tbl[1]  = '{1'b1, 32'h08, 32'h12345678, 32'h08, 32'h12345678};
        tbl[2]  = '{1'b1, 32'h1C, 32'hABCD1234, 32'h1C, 32'h1234};
        tbl[3]  = '{1'b1, 32'h24, 32'h55,       32'h24, 32'h0};
        tbl[4]  = '{1'b1, 32'hF8, 32'h77,       32'hF8, 32'h0};
        tbl[5]  = '{1'b1, 32'h3A, 32'h99,       32'h3A, 32'h0};
        tbl[6]  = '{1'b0, 32'h00, 32'h0,        32'h38, 32'h0};
        tbl[7]  = '{1'b1, 32'h30, 32'hFFFFFFF2, 32'h30, 32'h2};
        tbl[8]  = '{1'b1, 32'h30, 32'h8,        32'h30, 32'h8};
        tbl[9]  = '{1'b0, 32'h00, 32'h0,        32'h08, 32'h12345678};
        tbl[10] = '{1'b0, 32'h00, 32'h0,        32'h48, 32'h0};
        tbl[11] = '{1'b1, 32'h0C, 32'h5,        32'h0C, 32'h5};
        tbl[12] = '{1'b1, 32'h30, 32'h0,        32'h30, 32'h0};
        tbl[13] = '{1'b1, 32'h08, 32'h0,        32'h08, 32'h0};

        #1;
        chk("reset rd_data", rd_data_o, 32'h0);
        chk("reset irq", 32'(irq_o), 32'h0);
        chk("reset flag", 32'(timer_int_flag_o), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset rd_data", rd_data_o, 32'h0);

        for (int i = 0; i < 14; i++) begin
            wr_en_i = tbl[i].we;
            wr_addr_i = tbl[i].wa;
            wr_data_i = tbl[i].wd;
            rd_addr_i = tbl[i].ra;
            @(negedge clk);
            wr_en_i = 1'b0;
            chk($sformatf("tbl[%0d]", i), rd_data_o, tbl[i].ex);
        end

        // One-shot ch0: PEND 4 cycles after enable, EN drops.
        wr(32'h0C, 0);
        wr(32'h08, 3);
        rd_addr_i = 32'h00;
        wr(32'h00, 32'h3);
        wait_irq(0, 20, n);
        chk("os latency", n, 4);
        chk("os ctrl", rd_data_o, 32'h6);
        chk("os flag", 32'(timer_int_flag_o), 32'h1);
        rd_addr_i = 32'h04;
        @(negedge clk);
        chk("os count", rd_data_o, 32'h0);
        wr(32'h00, 0);
        chk("os clear", 32'(irq_o), 32'h0);

        // Periodic ch1 with prescale 2.
        wr(32'h1C, 2);
        wr(32'h18, 5);
        wr(32'h10, 32'hB);
        wait_irq(1, 40, n);
        chk("per first", n, 16);
        wr(32'h10, 32'hB);
        chk("per clear", 32'(irq_o[1]), 32'h0);
        wait_irq(1, 40, n);
        chk("per second", n, 15);
        rd_addr_i = 32'h10;
        @(negedge clk);
        chk("per ctrl", rd_data_o, 32'hF);
        wr(32'h10, 0);

        // Ch2 expiry coinciding with a CTRL write.
        wr(32'h2C, 0);
        wr(32'h28, 2);
        wr(32'h20, 32'h3);
        repeat (2) @(negedge clk);
        chk("coin pre", 32'(irq_o[2]), 32'h0);
        rd_addr_i = 32'h20;
        wr(32'h20, 32'h3);
        chk("coin ctrl", rd_data_o, 32'h7);
        rd_addr_i = 32'h24;
        @(negedge clk);
        chk("coin restart", rd_data_o, 32'h1);
        wr(32'h20, 0);
        chk("coin clear", 32'(irq_o[2]), 32'h0);

        // EVALUE=0 periodic: PEND every cycle, sticky past disable.
        wr(32'h28, 0);
        rd_addr_i = 32'h20;
        wr(32'h20, 32'h9);
        @(negedge clk);
        chk("ev0 pend", rd_data_o, 32'hD);
        wr(32'h20, 32'h9);
        chk("ev0 hw wins", rd_data_o, 32'hD);
        wr(32'h20, 32'h8);
        chk("ev0 disabled", rd_data_o, 32'hC);
        wr(32'h20, 0);
        chk("ev0 cleared", rd_data_o, 32'h0);

        // Lowering EVALUE below a running COUNT.
        wr(32'h3C, 0);
        wr(32'h08, 1000);
        wr(32'h00, 32'h1);
        wr(32'h38, 100);
        rd_addr_i = 32'h34;
        wr(32'h30, 32'h1);
        repeat (49) @(negedge clk);
        wr(32'h38, 10);
        chk("lower count", rd_data_o, 32'd50);
        rd_addr_i = 32'h30;
        @(negedge clk);
        chk("lower expire", rd_data_o, 32'h4);
        rd_addr_i = 32'h04;
        @(negedge clk);
        chk("lower ch0 count", rd_data_o, 32'd54);
        wr(32'h00, 0);
        wr(32'h30, 0);

        // Read latency and out-of-range reads.
        rd_addr_i = 32'h08;
        @(negedge clk);
        chk("rd ev", rd_data_o, 32'd1000);
        rd_addr_i = 32'hF4;
        #1;
        chk("rd latency", rd_data_o, 32'd1000);
        @(negedge clk);
        chk("rd ch15", rd_data_o, 32'h0);
        rd_addr_i = 32'h0E;
        @(negedge clk);
        chk("rd unmapped", rd_data_o, 32'h0);

        // Reset mid-count with PEND set.
        wr(32'h1C, 0);
        wr(32'h18, 3);
        rd_addr_i = 32'h10;
        wr(32'h10, 32'hB);
        wait_irq(1, 20, n);
        chk("rst setup", n, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("rst irq", 32'(irq_o), 32'h0);
        chk("rst flag", 32'(timer_int_flag_o), 32'h0);
        chk("rst rd", rd_data_o, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (irq_o != '0 || rd_data_o != 32'h0) seen++;
        end
        chk("rst no expiry", seen, 0);

        for (int k = 0; k < NCH; k++) begin
            m_en[k] = 0; m_ie[k] = 0; m_pend[k] = 0; m_mode[k] = 0;
            m_ev[k] = '0; m_pr[k] = '0; m_t[k] = 0;
        end

        for (int it = 0; it < 1500; it++) begin
            op = $urandom_range(0, 9);
            c = $urandom_range(0, NCH - 1);
            d = $urandom;
            we = 1'b1;
            a = '0;
            if (op <= 2) a = {24'd0, 4'(c), 4'h0};
            else if (op == 3) begin
                a = {24'd0, 4'(c), 4'h8};
                d = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 8);
            end else if (op == 4 && !m_en[c] && m_t[c] == 0) begin
                a = {24'd0, 4'(c), 4'hC};
                d = ($urandom << 16) | $urandom_range(0, 3);
            end else if (op == 5) begin
                off = $urandom_range(0, 15);
                if (off % 4 == 0 && off != 4) off++;
                a = $urandom_range(0, 1) ? {24'd0, 4'($urandom_range(NCH, 15)), 4'($urandom_range(0, 15))}
                                         : {24'd0, 4'(c), 4'(off)};
            end else we = 1'b0;
            ra = ($urandom_range(0, 3) != 0) ? {4'($urandom_range(0, NCH - 1)), 2'($urandom_range(0, 3)), 2'b00}
                                             : 8'($urandom_range(0, 255));
            for (int k = 0; k < NCH; k++) begin
                xp = m_en[k] && m_count(k) >= m_ev[k];
                m_t[k] = (!m_en[k] || xp) ? 0 : m_t[k] + 1;
                if (xp) begin
                    m_pend[k] = 1;
                    m_en[k] = m_mode[k];
                end
                if (we && a[7:4] == 4'(k)) begin
                    if (a[3:0] == 4'h0) begin
                        m_en[k] = d[0];
                        m_ie[k] = d[1];
                        m_mode[k] = d[3];
                        m_pend[k] = xp | (m_pend[k] & d[2]);
                    end
                    if (a[3:0] == 4'h8) m_ev[k] = d;
                    if (a[3:0] == 4'hC) m_pr[k] = d[15:0];
                end
                ex_irq[k] = m_pend[k] & m_ie[k];
            end
            m_rd = ra;
            wr_en_i = we;
            wr_addr_i = a;
            wr_data_i = d;
            rd_addr_i = {24'd0, ra};
            @(negedge clk);
            wr_en_i = 1'b0;
            chk("rand irq", 32'(irq_o), 32'(ex_irq));
            chk("rand flag", 32'(timer_int_flag_o), 32'(|ex_irq));
            chk("rand rd", rd_data_o, m_read(m_rd));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
